// File: rtl/freq_meter_bcd.sv
// rtl/freq_meter_bcd.sv - gated frequency meter with saturating packed-BCD result
// Counts synchronized rising edges of sig_in over GATE_CYCLES clocks and latches the total.
module freq_meter_bcd #(
  parameter int          GATE_CYCLES = 50_000_000,
  parameter logic [31:0] MAX_BCD     = 32'h9999_9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_in,
  input  logic        hold,
  output logic [31:0] bcd_cnt,
  output logic        valid,
  output logic        overflow
);

  localparam int            GW   = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

  logic          s1, s2, s3;
  logic          rise;
  logic [GW-1:0] gcnt;
  logic          terminal;
  logic [31:0]   acc;
  logic [31:0]   acc_next;
  logic          ovf_acc;
  logic          sat_hit;

  // Ripple the +1 through the digits: a 9 receiving a carry wraps to 0 and passes it on.
  function automatic logic [31:0] bcd_inc(input logic [31:0] v);
    logic [31:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign rise     = s2 & ~s3;
  assign terminal = (gcnt == LAST);
  assign sat_hit  = rise & (acc == MAX_BCD);

  // acc_next already includes a terminal-cycle edge, so it doubles as the closing value.
  always_comb begin
    acc_next = acc;
    if (rise && !sat_hit) begin
      acc_next = bcd_inc(acc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt <= '0;
    end else if (terminal) begin
      gcnt <= '0;
    end else begin
      gcnt <= gcnt + GW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
    end else if (terminal) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
    end else begin
      acc     <= acc_next;
      ovf_acc <= ovf_acc | sat_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_cnt  <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (terminal && !hold) begin
        bcd_cnt  <= acc_next;
        overflow <= ovf_acc | sat_hit;
        valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_bcd.sv
// tb/tb_freq_meter_bcd.sv - directed bench for freq_meter_bcd
// sig_in is scheduled per 100-cycle window; lvl(p) is the synchronized level seen in cycle p.
module tb_freq_meter_bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_in;
  logic        hold;

  logic [31:0] bcd_m, bcd_s, bcd_l;
  logic        vld_m, vld_s, vld_l;
  logic        ovf_m, ovf_s, ovf_l;

  int n_checks = 0;
  int n_fail   = 0;
  bit phase2   = 1'b0;

  always #5 clk = ~clk;

  freq_meter_bcd #(.GATE_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .hold(hold),
    .bcd_cnt(bcd_m), .valid(vld_m), .overflow(ovf_m)
  );

  freq_meter_bcd #(.GATE_CYCLES(100), .MAX_BCD(32'h0000_0015)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .hold(hold),
    .bcd_cnt(bcd_s), .valid(vld_s), .overflow(ovf_s)
  );

  freq_meter_bcd #(.GATE_CYCLES(200)) dut_long (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .hold(hold),
    .bcd_cnt(bcd_l), .valid(vld_l), .overflow(ovf_l)
  );

  // Modes: 0 low, 1 high, 2 period 10, 3 rise every odd cycle (50), 4 period 10 plus terminal rise,
  // 100+n: n rises on even positions 2..2n.
  int          mode_tab [18] = '{1, 1, 2, 2, 0, 109, 119, 0, 149, 3, 2, 4, 0, 2, 105, 107, 103, 2};
  bit          hold_tab [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
  logic [31:0] exp_main [17] = '{32'h1, 32'h0, 32'h10, 32'h10, 32'h0, 32'h9, 32'h19, 32'h0,
                                 32'h49, 32'h50, 32'h10, 32'h11, 32'h0, 32'h10, 32'h10, 32'h10, 32'h3};
  bit          sat_on   [17] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
  logic [31:0] sat_val  [17] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h15, 32'h0,
                                 32'h15, 32'h15, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  bit          sat_ovf  [17] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
  logic [31:0] exp_long [6]  = '{32'h1, 32'h20, 32'h9, 32'h19, 32'h99, 32'h21};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic lvl(input int p);
    int w, pos, m;
    w   = p / 100;
    pos = p % 100;
    if (phase2)     m = 2;
    else if (w > 17) m = 0;
    else            m = mode_tab[w];
    if (m >= 100) return (pos >= 2) && (pos % 2 == 0) && (pos <= 2 * (m - 100));
    case (m)
      1:       return 1'b1;
      2:       return (pos % 10) >= 5;
      3:       return (pos % 2) == 1;
      4:       return (pos == 99) ? 1'b1 : (pos == 98) ? 1'b0 : ((pos % 10) >= 5);
      default: return 1'b0;
    endcase
  endfunction

  // Window 13 toggles hold mid-window only; 14 and 15 hold across their terminal cycles.
  function automatic logic hold_for(input int c);
    int w, pos;
    w   = c / 100;
    pos = c % 100;
    if (w > 17) return 1'b0;
    if (hold_tab[w]) return 1'b1;
    return (w == 13) && (pos >= 20) && (pos <= 60);
  endfunction

  initial begin
    int early;
    rst_n  = 1'b0;
    sig_in = 1'b1;
    hold   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_bcd", bcd_m, 32'h0);
    check_eq("rst_valid", 32'(vld_m), 32'h0);
    check_eq("rst_ovf", 32'(ovf_m), 32'h0);

    rst_n = 1'b1;
    for (int c = 0; c < 1750; c++) begin
      if (c > 0 && c % 100 == 0) begin
        int w;
        w = c / 100 - 1;
        check_eq($sformatf("main_bcd_w%0d", w), bcd_m, exp_main[w]);
        check_eq($sformatf("main_valid_w%0d", w), 32'(vld_m), hold_tab[w] ? 32'h0 : 32'h1);
        check_eq($sformatf("main_ovf_w%0d", w), 32'(ovf_m), 32'h0);
        if (sat_on[w]) begin
          check_eq($sformatf("sat_bcd_w%0d", w), bcd_s, sat_val[w]);
          check_eq($sformatf("sat_ovf_w%0d", w), 32'(ovf_s), 32'(sat_ovf[w]));
          check_eq($sformatf("sat_valid_w%0d", w), 32'(vld_s), 32'h1);
        end
      end
      if (c > 100 && c % 100 == 1) begin
        check_eq($sformatf("main_pulse_c%0d", c), 32'(vld_m), 32'h0);
      end
      if (c > 0 && c % 200 == 0 && c / 200 <= 6) begin
        check_eq($sformatf("long_bcd_w%0d", c / 200 - 1), bcd_l, exp_long[c / 200 - 1]);
        check_eq($sformatf("long_valid_w%0d", c / 200 - 1), 32'(vld_l), 32'h1);
        check_eq($sformatf("long_ovf_w%0d", c / 200 - 1), 32'(ovf_l), 32'h0);
      end
      sig_in = lvl(c + 2);
      hold   = hold_for(c);
      @(negedge clk);
    end

    // Mid-window reset at gcnt = 50 of window 17.
    rst_n  = 1'b0;
    sig_in = 1'b0;
    #1;
    check_eq("mid_rst_bcd", bcd_m, 32'h0);
    check_eq("mid_rst_valid", 32'(vld_m), 32'h0);
    check_eq("mid_rst_ovf", 32'(ovf_m), 32'h0);
    check_eq("mid_rst_long_bcd", bcd_l, 32'h0);
    repeat (4) @(negedge clk);

    rst_n  = 1'b1;
    phase2 = 1'b1;
    early  = 0;
    for (int c = 0; c <= 100; c++) begin
      if (c >= 1 && c <= 99 && vld_m) early++;
      if (c == 99) begin
        check_eq("post_rst_early_valid", 32'(early), 32'h0);
        check_eq("post_rst_bcd_hold", bcd_m, 32'h0);
      end
      if (c == 100) begin
        check_eq("post_rst_valid", 32'(vld_m), 32'h1);
        check_eq("post_rst_bcd", bcd_m, 32'h10);
      end
      sig_in = lvl(c + 2);
      hold   = 1'b0;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_meter_bcd.md
# freq_meter_bcd

Gated frequency meter that counts rising edges of an external signal over a fixed window of system clocks and presents the result as an 8-digit packed BCD value. It sits directly upstream of the VGA picture generator and drives its `bcd_cnt` input: digit 7 is in [31:28] (leftmost on screen) and digit 0 is in [3:0]. With the default parameters at 50 MHz, the displayed value is the input frequency in Hz.

## Interface
- `GATE_CYCLES`, default 50_000_000: gate window length in `clk` cycles, at least 2.
- `MAX_BCD`, default 32'h9999_9999: saturation limit for the count. It must be a valid packed BCD value.
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst_n`  in  1: reset. Asynchronous assert, active-low.
- `sig_in`  in  1: measured signal, asynchronous to `clk`.
- `hold`  in  1: when 1, the output registers are frozen and measurement continues.
- `bcd_cnt`  out  32: latched count of the last completed window, packed BCD.
- `valid`  out  1: one-cycle pulse each time `bcd_cnt` is updated.
- `overflow`  out  1: set when the last latched window saturated at `MAX_BCD`.

## Operation
- Synchronizer: `sig_in` passes through `s1` then `s2`, followed by a history flop `s3`.
  - Rising edge is detected as `edge = s2 & ~s3`.
  - All three flops reset to 0. A `sig_in` held high through reset release therefore counts as one edge.
- Gate counter `gcnt`:
  - Counts 0 to GATE_CYCLES-1, then wraps to 0.
  - The terminal cycle is `gcnt == GATE_CYCLES-1`.
  - The counter is free-running and unaffected by `hold`.
- Accumulator `acc` (32-bit BCD):
  - On `edge`, increment by 1 in BCD. Digit i increments when every lower digit is 9; a digit that is 9 and receives a carry becomes 0.
  - If `acc == MAX_BCD` when `edge` occurs, `acc` stays at `MAX_BCD` and sticky `ovf_acc` is set.
- Terminal cycle behaviour:
  - Define `final = acc + edge`, with the same saturation rule, so an edge in the terminal cycle belongs to the closing window.
  - Define `final_ovf = ovf_acc | (edge & acc == MAX_BCD)`.
  - If `hold == 0`: `bcd_cnt <= final`, `overflow <= final_ovf`, and `valid` pulses next cycle.
  - If `hold == 1`: `bcd_cnt`, `overflow` and `valid` are unchanged.
  - In both cases, `acc <= 0` and `ovf_acc <= 0`. The next window starts clean, and an edge in the terminal cycle is not carried into it.
- Maximum countable input frequency is f_clk/2, because `sig_in` must be sampled low then high.
- Reset values: `bcd_cnt = 0`, `overflow = 0`, `valid = 0`, `acc = 0`, `gcnt = 0`, `ovf_acc = 0`, `s1..s3 = 0`.

## Timing
- A `sig_in` rise first sampled by `s1` at edge k gives `edge = 1` in cycle k+1, and `acc` is updated at edge k+2.
- Window n spans `gcnt` 0..GATE_CYCLES-1. `bcd_cnt`, `overflow` and `valid` update on the clock edge that ends the terminal cycle.
- The first update after reset occurs GATE_CYCLES edges after `rst_n` deasserts.
- `bcd_cnt` is stable for at least GATE_CYCLES cycles between updates, so the downstream display never sees a partial count.
- `hold` is sampled only in the terminal cycle. Rising or falling mid-window has no other effect.
- Reset asserted mid-window clears everything immediately, including `bcd_cnt`. The window restarts from `gcnt = 0` after release.
- BCD increment and saturation complete in a single cycle. No multicycle paths are allowed.

## Test plan
Sim with `GATE_CYCLES = 100`, `sig_in` low at reset release unless noted.
- Input period 10 (toggle every 5 clk): every window gives `bcd_cnt = 32'h0000_0010`, `overflow = 0`, and a `valid` pulse every 100 cycles.
- `sig_in` constant 0: `bcd_cnt = 0` and `valid` pulses each 100 cycles. Repeat with `sig_in` held 1 through reset: the first window gives `32'h0000_0001`, and later windows give 0.
- `MAX_BCD = 32'h0000_0015`, input at f_clk/2 (50 edges per window):
  - Required: `bcd_cnt = 32'h0000_0015` with `overflow = 1`.
  - Then drop to period 10: the next window gives `32'h0000_0010` with `overflow = 0`.
- BCD carry: input arranged to give 9, then 19, then 99 edges per window. Required values are `32'h0000_0009`, `32'h0000_0019` and `32'h0000_0099`, with no hex digits above 9.
- Terminal-edge ownership: force a single `edge` in the terminal cycle. That window reads previous+1, and the following window reads 0.
- `hold` and reset:
  - `hold = 1` across two terminal cycles while the input changes: `bcd_cnt` is unchanged and there is no `valid` pulse. After release, the next window shows the new value.
  - Assert `rst_n = 0` at `gcnt = 50`: all outputs go to 0 within the same cycle, and the first `valid` comes 100 cycles after release.
